// File: rtl/wptr_full_if.sv
// Write-side client/FIFO bundle for wptr_full: request, synchronised read
// pointer and overflow clear in; address, Gray pointer and status flags out.
interface wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  // Write-side client plus read-domain synchroniser side.
  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  // The pointer/flag generator itself.
  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-side pointer and flag generator (write clock domain only).
// Keeps a binary write count and its Gray image, compares against the
// synchronised Gray read pointer for full/level, and records overflow.
module wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic       wclk,
  input  logic       wrst_n,
  wptr_full_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic          wfull_q, wfull_d;
  logic          walmost_q, walmost_d;
  logic          wovf_q, wovf_d;
  logic          inc;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all
  // Gray bits from the MSB down to i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Next-state for pointers, full, level and overflow.
  always_comb begin
    inc       = bus.winc & ~wfull_q;
    wbin_d    = wbin_q + PW'(inc);
    wgray_d   = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is one whole lap ahead of the read pointer;
    // in Gray form that is the read pointer with its top two bits inverted.
    full_cmp  = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
    wfull_d   = (wgray_d == full_cmp);
    wlevel_d  = wbin_d - rbin;
    walmost_d = (wlevel_d >= THRESH);
    if (bus.winc & wfull_q)  wovf_d = 1'b1;
    else if (bus.wovf_clr)   wovf_d = 1'b0;
    else                     wovf_d = wovf_q;
  end

  // State registers; reset clears every output immediately.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q    <= '0;
      wgray_q   <= '0;
      wlevel_q  <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      wovf_q    <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      wgray_q   <= wgray_d;
      wlevel_q  <= wlevel_d;
      wfull_q   <= wfull_d;
      walmost_q <= walmost_d;
      wovf_q    <= wovf_d;
    end
  end

  assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr         = wgray_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;
endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (ADDRSIZE=4, AFULL_THRESH=12). The reference model
// counts accepted writes and reads as plain integers; flags and pointers are
// derived from the difference of those counts.
module tb_wptr_full;
  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic wclk;
  logic wrst_n;
  wptr_full_if #(.ADDRSIZE(AS)) bus ();

  wptr_full #(.ADDRSIZE(AS), .AFULL_THRESH(THR)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  int  m_wcnt;
  int  m_rcnt;
  bit  m_full;
  bit  m_ovf;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int m_level();
    return m_wcnt - m_rcnt;
  endfunction

  task automatic model_reset();
    m_wcnt = 0;
    m_rcnt = 0;
    m_full = 0;
    m_ovf  = 0;
  endtask

  // Drive one cycle of stimulus, clock it, and advance the model.
  task automatic cycle(input bit winc, input bit clr);
    bit acc;
    bus.winc     = winc;
    bus.wovf_clr = clr;
    bus.wq2_rptr = gray(m_rcnt);
    @(posedge wclk);
    acc = winc && !m_full;
    if (winc && m_full) m_ovf = 1;
    else if (clr)       m_ovf = 0;
    if (acc) m_wcnt++;
    m_full = (m_level() == DEPTH);
    #1;
  endtask

  task automatic test_reset();
    wrst_n       = 1'b0;
    bus.wq2_rptr = '0;
    bus.wovf_clr = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.winc = i[0];
      @(posedge wclk);
      #1;
    end
    n_total++;
    if ({bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow} !== '0)
      $display("FAIL reset_hold: outputs=%h want 0",
               {bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow});
    else n_pass++;
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0);
      n_total++;
      if ({bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow} !== '0)
        $display("FAIL reset_idle[%0d]: outputs=%h want 0", i,
                 {bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow});
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (bus.waddr !== 4'(i)) $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, bus.waddr, i);
      else n_pass++;
      cycle(1, 0);
      if (i == 10) begin
        n_total++;
        if (bus.wlevel !== 5'd11 || bus.walmost_full !== 1'b0)
          $display("FAIL afull_11: level=%0d af=%b want 11/0", bus.wlevel, bus.walmost_full);
        else n_pass++;
      end
      if (i == 11) begin
        n_total++;
        if (bus.wlevel !== 5'd12 || bus.walmost_full !== 1'b1)
          $display("FAIL afull_12: level=%0d af=%b want 12/1", bus.wlevel, bus.walmost_full);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.wfull !== 1'b1 || bus.wptr !== 5'b11000 || bus.wlevel !== 5'd16 || bus.waddr !== 4'd0)
      $display("FAIL fill_full: full=%b wptr=%b level=%0d waddr=%0d want 1/11000/16/0",
               bus.wfull, bus.wptr, bus.wlevel, bus.waddr);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0);
      n_total++;
      if (bus.wptr !== 5'b11000 || bus.woverflow !== 1'b1 || bus.waddr !== 4'd0)
        $display("FAIL ovf_hold[%0d]: wptr=%b ovf=%b waddr=%0d want 11000/1/0",
                 i, bus.wptr, bus.woverflow, bus.waddr);
      else n_pass++;
    end
    cycle(0, 1);
    n_total++;
    if (bus.woverflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.woverflow);
    else n_pass++;
    cycle(1, 1);
    n_total++;
    if (bus.woverflow !== 1'b1) $display("FAIL ovf_set_prio: got %b want 1", bus.woverflow);
    else n_pass++;
    cycle(0, 1);
    n_total++;
    if (bus.woverflow !== 1'b0) $display("FAIL ovf_clear2: got %b want 0", bus.woverflow);
    else n_pass++;
  endtask

  task automatic test_drain_wrap();
    m_rcnt = 16;
    cycle(0, 0);
    n_total++;
    if (bus.wfull !== 1'b0 || bus.wlevel !== 5'd0 || bus.walmost_full !== 1'b0)
      $display("FAIL drain: full=%b level=%0d af=%b want 0/0/0",
               bus.wfull, bus.wlevel, bus.walmost_full);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) cycle(1, 0);
    n_total++;
    if (bus.waddr !== 4'd0 || bus.wptr !== 5'b00000 || bus.wfull !== 1'b1 || bus.wlevel !== 5'd16)
      $display("FAIL wrap: waddr=%0d wptr=%b full=%b level=%0d want 0/00000/1/16",
               bus.waddr, bus.wptr, bus.wfull, bus.wlevel);
    else n_pass++;
  endtask

  task automatic test_random();
    wrst_n = 1'b0;
    #1;
    model_reset();
    wrst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && m_rcnt < m_wcnt) m_rcnt++;
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0));
      n_total++;
      if (bus.waddr !== 4'(m_wcnt) || bus.wptr !== gray(m_wcnt) ||
          bus.wfull !== m_full || bus.wlevel !== 5'(m_level()) ||
          bus.walmost_full !== (m_level() >= THR) || bus.woverflow !== m_ovf)
        $display("FAIL rand[%0d]: waddr=%0d wptr=%b full=%b level=%0d af=%b ovf=%b want %0d/%b/%b/%0d/%b/%b",
                 i, bus.waddr, bus.wptr, bus.wfull, bus.wlevel, bus.walmost_full, bus.woverflow,
                 m_wcnt % DEPTH, gray(m_wcnt), m_full, m_level(), m_level() >= THR, m_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    wrst_n = 1'b0;
    #1;
    model_reset();
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1, 0);
    n_total++;
    if (bus.waddr !== 4'd5 || bus.wlevel !== 5'd5)
      $display("FAIL pre_async: waddr=%0d level=%0d want 5/5", bus.waddr, bus.wlevel);
    else n_pass++;
    #1;
    wrst_n = 1'b0;
    #1;
    n_total++;
    if (bus.waddr !== 4'd0 || bus.wptr !== 5'd0 || bus.wlevel !== 5'd0)
      $display("FAIL async_reset: waddr=%0d wptr=%b level=%0d want 0/00000/0",
               bus.waddr, bus.wptr, bus.wlevel);
    else n_pass++;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag generator for the asynchronous FIFO, running entirely in the write clock domain. It sits directly upstream of the dual-port FIFO memory. It drives the memory's write address and full flag, and publishes a Gray-coded write pointer for synchronisation into the read domain. It also provides an almost-full flag, a conservative fill level and a sticky overflow flag for the write-side client.

## Interface
- ADDRSIZE, 4, memory address bits; FIFO depth = 2^ADDRSIZE; legal range ADDRSIZE >= 2
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE
- wclk  in  1  write-domain clock, rising edge; the only clock in the block
- wrst_n  in  1  asynchronous, active-low reset
- winc  in  1  write request from the client; accepted only when wfull=0
- wq2_rptr  in  ADDRSIZE+1  read pointer, Gray-coded, already through the 2-flop synchroniser into wclk
- wovf_clr  in  1  clears woverflow
- waddr  out  ADDRSIZE  memory write address (to fifomem waddr)
- wptr  out  ADDRSIZE+1  Gray write pointer (to the read-domain synchroniser)
- wfull  out  1  FIFO full (to fifomem wfull and the client)
- walmost_full  out  1  fill level >= AFULL_THRESH
- wlevel  out  ADDRSIZE+1  fill level, range 0..2^ADDRSIZE
- woverflow  out  1  sticky flag: a write was attempted while full

## Operation
- State registers: wbin (ADDRSIZE+1, binary), wptr (Gray), wfull, walmost_full, wlevel, woverflow.
- Write enable: inc = winc & ~wfull.
- Pointer update:
  - wbinnext = wbin + inc, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - Both wbin and wptr register their next values every cycle.
- waddr = wbin[ADDRSIZE-1:0]. It is taken from a register output, so no combinational path runs from winc to waddr.
- Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Level:
  - rbin = Gray-to-binary of wq2_rptr, computed as an XOR prefix from the MSB down.
  - wlevel <= wbinnext - rbin, modulo 2^(ADDRSIZE+1).
  - walmost_full <= (wbinnext - rbin) >= AFULL_THRESH.
- Overflow:
  - woverflow <= 1 if (winc & wfull).
  - Otherwise woverflow <= 0 if wovf_clr.
  - Otherwise woverflow holds.
  - Set has priority over clear in the same cycle.
- Writes while full are dropped: wbin, wptr and waddr are unchanged.
- Wrap-around: wbin wraps from 2^(ADDRSIZE+1)-1 to 0, and wptr wraps with it. The MSB toggles once per pass through the memory, which is what distinguishes full from empty.

## Timing
- Reset: wrst_n=0 immediately forces every output to 0 (waddr, wptr, wfull, walmost_full, wlevel, woverflow). No clock edge is needed. Deassertion is synchronised outside this block.
- Reset asserted mid-operation discards all state, with no partial update.
- Write latency:
  - When winc=1 and wfull=0 at an edge, fifomem writes the data at the current waddr on that same edge.
  - waddr and wptr advance at that edge.
  - wptr reaches the read domain two rclk cycles later, through the external synchroniser.
- wfull asserts at the same edge that accepts the final write, so the next cycle already blocks further writes.
- wfull deasserts on the first wclk edge after wq2_rptr changes. Because of the synchroniser lag this is pessimistic (late), and never early.
- wlevel and walmost_full are registered and updated every edge. They may overestimate the true level by up to the synchroniser lag; they never underestimate it.
- winc and wq2_rptr changing in the same cycle: both are applied in the same next-state computation.
- wq2_rptr must change by at most one Gray step per wclk cycle. Multi-bit jumps are outside the spec.

## Test plan
All scenarios use ADDRSIZE=4 and AFULL_THRESH=12.
- Reset: hold wrst_n=0 with winc=1 toggling -> all outputs 0. Release wrst_n with winc=0 for 5 cycles -> outputs stay 0.
- Fill: wq2_rptr=0, winc=1 for 16 edges -> waddr steps 0..15. After the 16th edge: wfull=1, wptr=5'b11000, wlevel=16, waddr=0.
- Almost-full boundary: after 11 accepted writes, wlevel=11 and walmost_full=0. After the 12th, wlevel=12 and walmost_full=1.
- Overflow while full: winc=1 for 3 more cycles -> wptr remains 5'b11000 and woverflow=1 after the first of these edges. Then:
  - wovf_clr=1 alone -> woverflow=0 next edge.
  - winc=1 with wovf_clr=1 in the same cycle -> woverflow=1.
- Drain and wrap:
  - Set wq2_rptr=5'b11000 -> next edge wfull=0, wlevel=0, walmost_full=0.
  - Write 16 more -> waddr wraps 15 to 0, wptr=5'b00000, wfull=1, wlevel=16.
- Async reset mid-fill: after 5 accepted writes, pull wrst_n low between edges -> waddr, wptr and wlevel read 0 before the next wclk edge.
